// File: rtl/pipe_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-wide lookahead group per stage,
// with the operands and partial sums skewed forward beside each beat under a single valid/ready stall.
module pipe_cla_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / BLOCK;

    // Per-stage beat: the operand b is stored already conditioned for subtraction,
    // and carry holds the carry out of the most recently resolved group.
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [WIDTH-1:0] op_a;
        logic [WIDTH-1:0] op_b;
        logic [WIDTH-1:0] res;
    } beat_t;

    beat_t stage_q [STAGES];
    beat_t stage_d [STAGES];
    logic  ovf_q;
    logic  ovf_d;
    logic  adv;

    // Flat sum-of-products lookahead: every group carry comes straight from p/g and c0.
    function automatic logic [BLOCK:0] cla_carries(input logic [BLOCK-1:0] p,
                                                   input logic [BLOCK-1:0] g,
                                                   input logic             c0);
        logic [BLOCK:0] c;
        logic           pp;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < int'(BLOCK); i++) begin
            pp = 1'b1;
            for (int j = i; j >= 0; j--) begin
                c[i+1] = c[i+1] | (g[j] & pp);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & c0);
        end
        return c;
    endfunction

    assign adv      = !stage_q[STAGES-1].valid || out_ready;
    assign in_ready = adv;

    // Stage k resolves its group from the beat held by stage k-1 (stage 0: the input beat).
    always_comb begin
        beat_t          src;
        logic [BLOCK:0] cc;
        logic [BLOCK-1:0] pb;
        logic [BLOCK-1:0] gb;

        stage_d   = stage_q;
        ovf_d     = 1'b0;
        cc        = '0;
        pb        = '0;
        gb        = '0;
        src       = '0;
        src.valid = in_valid;
        src.carry = cin ^ sub;
        src.op_a  = a;
        src.op_b  = sub ? ~b : b;

        for (int k = 0; k < int'(STAGES); k++) begin
            pb = src.op_a[k*int'(BLOCK) +: BLOCK] ^ src.op_b[k*int'(BLOCK) +: BLOCK];
            gb = src.op_a[k*int'(BLOCK) +: BLOCK] & src.op_b[k*int'(BLOCK) +: BLOCK];
            cc = cla_carries(pb, gb, src.carry);

            stage_d[k]                           = src;
            stage_d[k].res[k*int'(BLOCK) +: BLOCK] = pb ^ cc[BLOCK-1:0];
            stage_d[k].carry                     = cc[BLOCK];

            if (k == int'(STAGES) - 1) begin
                ovf_d = cc[BLOCK] ^ cc[BLOCK-1];
            end

            src = stage_q[k];
        end
    end

    // Whole pipeline, bubbles included, moves only when the output slot can take a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                stage_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            stage_q <= stage_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = stage_q[STAGES-1].valid;
    assign sum       = stage_q[STAGES-1].res;
    assign cout      = stage_q[STAGES-1].carry;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Bench for pipe_cla_addsub: directed vectors, stall and reset cases on the default
// 8/4 build, plus randomized traffic on 8/4, 32/8 and 8/8 builds against an arithmetic model.
module tb_pipe_cla_addsub;

    localparam int unsigned N = 3;
    localparam int unsigned WID [N] = '{8, 32, 8};

    logic        clk;
    logic        rst_n;
    logic        in_valid_r  [N];
    logic        out_ready_r [N];
    logic        cin_r       [N];
    logic        sub_r       [N];
    logic [31:0] a_r         [N];
    logic [31:0] b_r         [N];
    logic        in_ready_w  [N];
    logic        out_valid_w [N];
    logic        cout_w      [N];
    logic        ovf_w       [N];
    logic [7:0]  sum0;
    logic [31:0] sum1;
    logic [7:0]  sum2;

    int          errors;
    int          checks;
    logic [33:0] exp_q   [N][$];
    logic        stalled [N];
    logic [33:0] held    [N];
    logic        acc     [N];

    pipe_cla_addsub #(.WIDTH(8), .BLOCK(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_r[0]), .in_ready(in_ready_w[0]),
        .a(a_r[0][7:0]), .b(b_r[0][7:0]), .cin(cin_r[0]), .sub(sub_r[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready_r[0]),
        .sum(sum0), .cout(cout_w[0]), .ovf(ovf_w[0]));

    pipe_cla_addsub #(.WIDTH(32), .BLOCK(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_r[1]), .in_ready(in_ready_w[1]),
        .a(a_r[1]), .b(b_r[1]), .cin(cin_r[1]), .sub(sub_r[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready_r[1]),
        .sum(sum1), .cout(cout_w[1]), .ovf(ovf_w[1]));

    pipe_cla_addsub #(.WIDTH(8), .BLOCK(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_r[2]), .in_ready(in_ready_w[2]),
        .a(a_r[2][7:0]), .b(b_r[2][7:0]), .cin(cin_r[2]), .sub(sub_r[2]),
        .out_valid(out_valid_w[2]), .out_ready(out_ready_r[2]),
        .sum(sum2), .cout(cout_w[2]), .ovf(ovf_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mask_of(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << w) - 64'd1);
    endfunction

    // Plain integer arithmetic: unsigned result for sum/cout, signed result range for ovf.
    function automatic logic [33:0] ref_model(input int unsigned w, input logic [31:0] x,
                                              input logic [31:0] y, input logic c, input logic s);
        longint m, ux, uy, sx, sy, u, r;
        logic   co, ov;
        m  = longint'(64'd1 << w);
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        sx = x[w-1] ? ux - m : ux;
        sy = y[w-1] ? uy - m : uy;
        if (s) begin
            u  = ux - uy - longint'(c);
            r  = sx - sy - longint'(c);
            co = (u >= 0);
        end else begin
            u  = ux + uy + longint'(c);
            r  = sx + sy + longint'(c);
            co = (u >= m);
        end
        ov = (r >= m / 2) || (r < -(m / 2));
        return {ov, co, 32'(u & (m - 1))};
    endfunction

    function automatic logic [33:0] obs(input int i);
        case (i)
            0:       return {ovf_w[0], cout_w[0], 24'd0, sum0};
            1:       return {ovf_w[1], cout_w[1], sum1};
            default: return {ovf_w[2], cout_w[2], 24'd0, sum2};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Scoreboard pass just after the drive edge, then advance one full clock.
    task automatic tick();
        #1;
        for (int i = 0; i < int'(N); i++) begin
            acc[i] = rst_n && in_valid_r[i] && in_ready_w[i];
            if (rst_n) begin
                if (stalled[i]) begin
                    check("stall_valid", 64'(out_valid_w[i]), 64'd1);
                    check("stall_hold", 64'(obs(i)), 64'(held[i]));
                end
                if (out_valid_w[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check("spurious_out", 64'(out_valid_w[i]), 64'd0);
                    end else begin
                        check("result", 64'(obs(i)), 64'(exp_q[i][0]));
                        if (out_ready_r[i]) void'(exp_q[i].pop_front());
                    end
                end
                stalled[i] = out_valid_w[i] && !out_ready_r[i];
                held[i]    = obs(i);
                if (acc[i]) exp_q[i].push_back(ref_model(WID[i], a_r[i], b_r[i], cin_r[i], sub_r[i]));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic directed(input string tag, input logic [7:0] x, input logic [7:0] y,
                            input logic c, input logic s, input logic [7:0] es,
                            input logic ec, input logic eo);
        in_valid_r[0] = 1'b1;
        a_r[0] = {24'd0, x};
        b_r[0] = {24'd0, y};
        cin_r[0] = c;
        sub_r[0] = s;
        tick();
        in_valid_r[0] = 1'b0;
        check({tag, "_lat1"}, 64'(out_valid_w[0]), 64'd0);
        tick();
        check({tag, "_valid"}, 64'(out_valid_w[0]), 64'd1);
        check({tag, "_sum"}, 64'(sum0), 64'(es));
        check({tag, "_cout"}, 64'(cout_w[0]), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf_w[0]), 64'(eo));
    endtask

    task automatic rand_beat(input int i);
        a_r[i]   = $urandom & mask_of(WID[i]);
        b_r[i]   = $urandom & mask_of(WID[i]);
        cin_r[i] = 1'($urandom_range(0, 1));
        sub_r[i] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int sent;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            in_valid_r[i] = 1'b0; out_ready_r[i] = 1'b1; cin_r[i] = 1'b0; sub_r[i] = 1'b0;
            a_r[i] = '0; b_r[i] = '0; stalled[i] = 1'b0; held[i] = '0; acc[i] = 1'b0;
        end
        @(negedge clk);
        tick();
        for (int i = 0; i < int'(N); i++) begin
            check("rst_out_valid", 64'(out_valid_w[i]), 64'd0);
            check("rst_in_ready", 64'(in_ready_w[i]), 64'd1);
            check("rst_result", 64'(obs(i)), 64'd0);
        end
        rst_n = 1'b1;
        tick();

        directed("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        directed("sub_borrow", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        directed("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        directed("xcarry", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        directed("wrap_cin", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        directed("sub_bin", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0);
        tick();

        // Back-to-back beats: every beat taken, output busy every cycle after fill.
        for (int n = 0; n < 8; n++) begin
            in_valid_r[0] = 1'b1;
            rand_beat(0);
            tick();
            check("tp_accept", 64'(acc[0]), 64'd1);
            if (n >= 1) check("tp_busy", 64'(out_valid_w[0]), 64'd1);
        end
        in_valid_r[0] = 1'b0;
        for (int n = 0; n < 3; n++) tick();
        check("tp_drain", 64'(exp_q[0].size()), 64'd0);

        // Five beats with a three-cycle output stall in the middle.
        sent = 0;
        rand_beat(0);
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_valid_r[0]  = (sent < 5);
            out_ready_r[0] = !(cyc >= 3 && cyc <= 5);
            tick();
            if (cyc >= 3 && cyc <= 5) check("bp_in_ready", 64'(acc[0]), 64'd0);
            if (acc[0]) begin
                sent++;
                rand_beat(0);
            end
        end
        in_valid_r[0]  = 1'b0;
        out_ready_r[0] = 1'b1;
        for (int n = 0; n < 3; n++) tick();
        check("bp_sent", 64'(sent), 64'd5);
        check("bp_drain", 64'(exp_q[0].size()), 64'd0);

        // Reset between edges with two beats in flight.
        in_valid_r[0] = 1'b1; rand_beat(0); tick();
        rand_beat(0); tick();
        in_valid_r[0] = 1'b0;
        check("pre_rst_valid", 64'(out_valid_w[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(out_valid_w[0]), 64'd0);
        check("rst_async_sum", 64'(obs(0)), 64'd0);
        check("rst_async_ready", 64'(in_ready_w[0]), 64'd1);
        for (int i = 0; i < int'(N); i++) begin
            exp_q[i].delete();
            stalled[i] = 1'b0;
        end
        @(negedge clk);
        in_valid_r[0] = 1'b1;
        rand_beat(0);
        tick();
        tick();
        in_valid_r[0] = 1'b0;
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            check("rst_stale", 64'(out_valid_w[0]), 64'd0);
        end

        // Randomized traffic on all three builds.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < int'(N); i++) begin
                in_valid_r[i]  = ($urandom_range(0, 3) != 0);
                out_ready_r[i] = ($urandom_range(0, 3) != 0);
                rand_beat(i);
            end
            tick();
        end
        for (int i = 0; i < int'(N); i++) begin
            in_valid_r[i]  = 1'b0;
            out_ready_r[i] = 1'b1;
        end
        for (int n = 0; n < 6; n++) tick();
        for (int i = 0; i < int'(N); i++) begin
            check("rand_drain", 64'(exp_q[i].size()), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
